// File: rtl/rr_arbiter_hold.sv
// N-way round-robin arbiter with registered one-hot grant and multi-cycle
// ownership: the owner keeps the grant until it signals last, drops its
// request, or reaches MAX_HOLD cycles. Handover has no bubble cycle.
module rr_arbiter_hold #(
  parameter int unsigned N        = 4,
  parameter int unsigned MAX_HOLD = 8,
  parameter int unsigned IDW      = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   req,
  input  logic [N-1:0]   last,
  output logic [N-1:0]   gnt,
  output logic           gnt_valid,
  output logic [IDW-1:0] gnt_id,
  output logic           expired
);

  localparam int unsigned CW = $clog2(MAX_HOLD + 1);

  logic [CW-1:0]  cnt;
  logic [IDW-1:0] ptr;

  logic [N-1:0]   gnt_nxt;
  logic           gnt_valid_nxt;
  logic [IDW-1:0] gnt_id_nxt;
  logic           expired_nxt;
  logic [CW-1:0]  cnt_nxt;
  logic [IDW-1:0] ptr_nxt;

  logic [IDW-1:0] own_inc;
  logic [IDW-1:0] scan_start;
  logic           win_found;
  logic [IDW-1:0] win_id;
  logic           rel_drop;
  logic           rel_last;
  logic           rel_max;

  // Owner index plus one, wrapping at N-1 (N need not be a power of two)
  always_comb begin
    own_inc = gnt_id + IDW'(1);
    if (gnt_id == IDW'(N - 1)) begin
      own_inc = '0;
    end
  end

  // Release conditions for the current owner
  always_comb begin
    rel_drop = ~req[gnt_id];
    rel_last = req[gnt_id] & last[gnt_id];
    rel_max  = (cnt == CW'(MAX_HOLD));
  end

  // Find the first requester at or after the scan start, modulo N
  always_comb begin
    scan_start = gnt_valid ? own_inc : ptr;
    win_found  = 1'b0;
    win_id     = '0;
    for (int unsigned k = 0; k < N; k++) begin
      int unsigned j;
      j = 32'(scan_start) + k;
      if (j >= N) begin
        j = j - N;
      end
      if (!win_found && req[IDW'(j)]) begin
        win_found = 1'b1;
        win_id    = IDW'(j);
      end
    end
  end

  // Next-state and next-output logic: idle arbitration, hold, release/handover
  always_comb begin
    gnt_nxt       = gnt;
    gnt_valid_nxt = gnt_valid;
    gnt_id_nxt    = gnt_id;
    expired_nxt   = 1'b0;
    cnt_nxt       = cnt;
    ptr_nxt       = ptr;

    if (!gnt_valid) begin
      if (win_found) begin
        gnt_valid_nxt = 1'b1;
        gnt_id_nxt    = win_id;
        cnt_nxt       = CW'(1);
        for (int unsigned i = 0; i < N; i++) begin
          gnt_nxt[i] = (IDW'(i) == win_id);
        end
      end
    end else if (!(rel_drop || rel_last || rel_max)) begin
      cnt_nxt = cnt + CW'(1);
    end else begin
      ptr_nxt     = own_inc;
      expired_nxt = rel_max & ~rel_drop & ~rel_last;
      if (win_found) begin
        gnt_id_nxt = win_id;
        cnt_nxt    = CW'(1);
        for (int unsigned i = 0; i < N; i++) begin
          gnt_nxt[i] = (IDW'(i) == win_id);
        end
      end else begin
        gnt_valid_nxt = 1'b0;
        gnt_nxt       = '0;
        cnt_nxt       = '0;
      end
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt       <= '0;
      gnt_valid <= 1'b0;
      gnt_id    <= '0;
      expired   <= 1'b0;
      cnt       <= '0;
      ptr       <= '0;
    end else begin
      gnt       <= gnt_nxt;
      gnt_valid <= gnt_valid_nxt;
      gnt_id    <= gnt_id_nxt;
      expired   <= expired_nxt;
      cnt       <= cnt_nxt;
      ptr       <= ptr_nxt;
    end
  end

endmodule

// File: tb/tb_rr_arbiter_hold.sv
// Directed bench for rr_arbiter_hold, N=4, MAX_HOLD=4.
module tb_rr_arbiter_hold;

  localparam int unsigned N        = 4;
  localparam int unsigned MAX_HOLD = 4;
  localparam int unsigned IDW      = 2;

  logic           clk;
  logic           rst_n;
  logic [N-1:0]   req;
  logic [N-1:0]   last;
  logic [N-1:0]   gnt;
  logic           gnt_valid;
  logic [IDW-1:0] gnt_id;
  logic           expired;

  int unsigned n_vec;
  int unsigned n_err;

  rr_arbiter_hold #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .last      (last),
    .gnt       (gnt),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id),
    .expired   (expired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count one comparison and report a miscompare
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = '0;
    last  = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic chk_gnt(input string tag, input logic [N-1:0] eg, input logic [IDW-1:0] eid,
                         input logic eexp);
    chk({tag, ".gnt"}, 32'(gnt), 32'(eg));
    chk({tag, ".valid"}, 32'(gnt_valid), 32'(|eg));
    if (eg != '0) chk({tag, ".id"}, 32'(gnt_id), 32'(eid));
    chk({tag, ".exp"}, 32'(expired), 32'(eexp));
  endtask

  initial begin
    logic [N-1:0] rot_exp [5];
    logic [IDW-1:0] rot_id [5];
    n_vec = 0;
    n_err = 0;
    rot_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    rot_id  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

    // Reset state
    do_reset();
    #1;
    chk("rst.gnt", 32'(gnt), 32'h0);
    chk("rst.valid", 32'(gnt_valid), 32'h0);
    chk("rst.id", 32'(gnt_id), 32'h0);
    chk("rst.exp", 32'(expired), 32'h0);

    // 1: rotation with last pulsed by each owner
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      step();
      chk_gnt($sformatf("rot%0d", i), rot_exp[i], rot_id[i], 1'b0);
      last = gnt;
    end
    req  = '0;
    last = '0;
    step();
    chk_gnt("rot.idle", 4'b0000, 2'd0, 1'b0);

    // 2: tenure limit, sole requester
    do_reset();
    req = 4'b0100;
    for (int i = 0; i < 4; i++) begin
      step();
      chk_gnt($sformatf("hold%0d", i), 4'b0100, 2'd2, 1'b0);
    end
    step();
    chk_gnt("hold.regrant", 4'b0100, 2'd2, 1'b1);
    chk("hold.cnt", 32'(dut.cnt), 32'd1);
    step();
    chk_gnt("hold.after", 4'b0100, 2'd2, 1'b0);

    // 3: forced release with contention
    do_reset();
    req = 4'b0011;
    for (int i = 0; i < 4; i++) begin
      step();
      chk_gnt($sformatf("force%0d", i), 4'b0001, 2'd0, 1'b0);
    end
    step();
    chk_gnt("force.hand", 4'b0010, 2'd1, 1'b1);

    // 4: request drop, owner still sees gnt that cycle, then idle
    do_reset();
    req = 4'b0001;
    step();
    chk_gnt("drop.g0", 4'b0001, 2'd0, 1'b0);
    step();
    req = 4'b0000;
    chk_gnt("drop.g1", 4'b0001, 2'd0, 1'b0);
    step();
    chk_gnt("drop.idle", 4'b0000, 2'd0, 1'b0);
    chk("drop.idhold", 32'(gnt_id), 32'd0);
    req = 4'b0001;
    step();
    chk_gnt("drop.regnt", 4'b0001, 2'd0, 1'b0);

    // 5: wrap-around from owner 3
    do_reset();
    req = 4'b1000;
    step();
    chk_gnt("wrap.own3", 4'b1000, 2'd3, 1'b0);
    req  = 4'b1001;
    last = 4'b1000;
    step();
    chk_gnt("wrap.hand", 4'b0001, 2'd0, 1'b0);
    chk("wrap.ptr", 32'(dut.ptr), 32'd0);
    last = '0;

    // 6: asynchronous reset mid-tenure
    do_reset();
    req = 4'b0011;
    step();
    step();
    chk_gnt("arst.pre", 4'b0001, 2'd0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst.gnt", 32'(gnt), 32'h0);
    chk("arst.valid", 32'(gnt_valid), 32'h0);
    req = 4'b1010;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk_gnt("arst.first", 4'b0010, 2'd1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
